// File: rtl/ksa_pkg.sv
// ---------------------------------------------------------------------------
// ksa_pkg
// Shared types and constants for the RC4 key-scheduling block.
//   ksa_state_t    : FSM state encoding used by ksa
//   KSA_DATA_WIDTH : default S word / address width
//   KSA_KEY_BYTES  : default secret key length in bytes
//   S_LAST         : highest S index for the default width (last iteration)
//   key_byte_t     : one byte of the secret key
//   key_idx_width  : width of the key byte index counter for a given key length
// ---------------------------------------------------------------------------
package ksa_pkg;

  localparam int KSA_DATA_WIDTH = 8;
  localparam int KSA_KEY_BYTES  = 3;
  localparam int S_LAST         = (1 << KSA_DATA_WIDTH) - 1;

  typedef logic [7:0] key_byte_t;

  typedef enum logic [3:0] {
    IDLE,
    RD_I,
    WT_I,
    CALC_J,
    RD_J,
    WT_J,
    WR_I,
    WR_J,
    DONE
  } ksa_state_t;

  // A single-byte key still needs a 1-bit index register.
  function automatic int key_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_byte_sel.sv
// ---------------------------------------------------------------------------
// key_byte_sel
// Selects one byte of the secret key by index. Byte 0 is the most significant
// byte of secret_key (big-endian order), matching the usual RC4 key layout.
//   secret_key : in  8*KEY_BYTES  full key
//   k          : in  K_W          byte index, 0..KEY_BYTES-1
//   key_byte   : out 8            selected byte (0 for an out-of-range index)
// Purely combinational.
// ---------------------------------------------------------------------------
module key_byte_sel
  import ksa_pkg::*;
#(
  parameter int KEY_BYTES = KSA_KEY_BYTES,
  parameter int K_W       = key_idx_width(KSA_KEY_BYTES)
) (
  input  logic [8*KEY_BYTES-1:0] secret_key,
  input  logic [K_W-1:0]         k,
  output key_byte_t              key_byte
);

  key_byte_t key_bytes [KEY_BYTES];

  genvar gi;
  generate
    for (gi = 0; gi < KEY_BYTES; gi++) begin : g_split
      // Byte gi sits gi bytes down from the top of the key vector.
      assign key_bytes[gi] = secret_key[8*(KEY_BYTES-gi)-1 -: 8];
    end
  endgenerate

  always_comb begin
    key_byte = '0;
    for (int b = 0; b < KEY_BYTES; b++) begin
      if (k == K_W'(b)) begin
        key_byte = key_bytes[b];
      end
    end
  end

endmodule

// File: rtl/ksa.sv
// ---------------------------------------------------------------------------
// ksa
// RC4 key-scheduling stage. Assumes S[a]=a has already been written to the
// external single-port S memory. For i = 0..2^DATA_WIDTH-1 it computes
//   j = j + S[i] + key[i mod KEY_BYTES]   (mod 2^DATA_WIDTH)
// and swaps S[i] and S[j], then raises finish and stays done until reset.
//
// Ports
//   clk        : in  1             rising-edge clock
//   rst_n      : in  1             asynchronous active-low reset
//   start      : in  1             level, only looked at while idle
//   secret_key : in  8*KEY_BYTES   held stable from start until finish
//   address    : out DATA_WIDTH    S memory address
//   data       : out DATA_WIDTH    S memory write data (0 unless writing)
//   q          : in  DATA_WIDTH    S memory read data, one cycle after address
//   wren       : out 1             S memory write enable
//   finish     : out 1             sticky done flag
//
// Optional feature macro: KSA_SWAP_SKIP_EN
//   When defined, an iteration with j == i skips both writes and returns to
//   the next read straight from WT_J (5 cycles instead of 7). Without it every
//   iteration takes 7 cycles and always writes, so a run is 1792 cycles.
//
// All outputs are registered: each transition loads the address/data/wren
// values that belong to the state being entered, so they are valid for the
// whole cycle the FSM spends in that state.
// ---------------------------------------------------------------------------
module ksa
  import ksa_pkg::*;
#(
  parameter int DATA_WIDTH = KSA_DATA_WIDTH,
  parameter int KEY_BYTES  = KSA_KEY_BYTES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [8*KEY_BYTES-1:0]  secret_key,
  output logic [DATA_WIDTH-1:0]   address,
  output logic [DATA_WIDTH-1:0]   data,
  input  logic [DATA_WIDTH-1:0]   q,
  output logic                    wren,
  output logic                    finish
);

  localparam int                  K_W    = key_idx_width(KEY_BYTES);
  localparam logic [DATA_WIDTH-1:0] I_LAST = '1;
  localparam logic [K_W-1:0]      K_LAST = K_W'(KEY_BYTES - 1);

  ksa_state_t              state_reg;
  logic [DATA_WIDTH-1:0]   i_reg;
  logic [DATA_WIDTH-1:0]   j_reg;
  logic [K_W-1:0]          k_reg;
  logic [DATA_WIDTH-1:0]   si_reg;
  logic [DATA_WIDTH-1:0]   sj_reg;

  logic [DATA_WIDTH-1:0]   address_reg;
  logic [DATA_WIDTH-1:0]   data_reg;
  logic                    wren_reg;
  logic                    finish_reg;

  key_byte_t               key_byte;
  logic [DATA_WIDTH-1:0]   j_next;
  logic [DATA_WIDTH-1:0]   i_next;
  logic [K_W-1:0]          k_next;
  logic                    last_iter;

  key_byte_sel #(
    .KEY_BYTES (KEY_BYTES),
    .K_W       (K_W)
  ) u_key_byte_sel (
    .secret_key (secret_key),
    .k          (k_reg),
    .key_byte   (key_byte)
  );

  // Natural wrap of the DATA_WIDTH-bit sum gives the mod 2^DATA_WIDTH.
  assign j_next    = j_reg + si_reg + DATA_WIDTH'(key_byte);
  assign i_next    = i_reg + DATA_WIDTH'(1);
  // Key index is a wrap counter that tracks i mod KEY_BYTES without a divider.
  assign k_next    = (k_reg == K_LAST) ? '0 : k_reg + K_W'(1);
  assign last_iter = (i_reg == I_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      i_reg       <= '0;
      j_reg       <= '0;
      k_reg       <= '0;
      si_reg      <= '0;
      sj_reg      <= '0;
      address_reg <= '0;
      data_reg    <= '0;
      wren_reg    <= 1'b0;
      finish_reg  <= 1'b0;
    end else begin
      // Only the two write states drive data/wren; everything else is quiet.
      wren_reg <= 1'b0;
      data_reg <= '0;

      case (state_reg)
        IDLE: begin
          address_reg <= '0;
          if (start) begin
            state_reg   <= RD_I;
            address_reg <= i_reg;
          end
        end

        RD_I: begin
          state_reg   <= WT_I;
          address_reg <= i_reg;
        end

        WT_I: begin
          // q now holds S[i] for the address presented in RD_I.
          si_reg      <= q;
          state_reg   <= CALC_J;
          address_reg <= i_reg;
        end

        CALC_J: begin
          j_reg       <= j_next;
          state_reg   <= RD_J;
          address_reg <= j_next;
        end

        RD_J: begin
          state_reg   <= WT_J;
          address_reg <= j_reg;
        end

        WT_J: begin
          sj_reg <= q;
`ifdef KSA_SWAP_SKIP_EN
          if (j_reg == i_reg) begin
            // Self-swap leaves S unchanged: skip both writes and advance.
            if (last_iter) begin
              state_reg   <= DONE;
              address_reg <= '0;
              finish_reg  <= 1'b1;
            end else begin
              i_reg       <= i_next;
              k_reg       <= k_next;
              state_reg   <= RD_I;
              address_reg <= i_next;
            end
          end else begin
            state_reg   <= WR_I;
            address_reg <= i_reg;
            data_reg    <= q;
            wren_reg    <= 1'b1;
          end
`else
          // S[j] goes straight from q into the write data for WR_I.
          state_reg   <= WR_I;
          address_reg <= i_reg;
          data_reg    <= q;
          wren_reg    <= 1'b1;
`endif
        end

        WR_I: begin
          state_reg   <= WR_J;
          address_reg <= j_reg;
          data_reg    <= si_reg;
          wren_reg    <= 1'b1;
        end

        WR_J: begin
          // i stops at its last value; it never wraps back to 0 inside a run.
          if (last_iter) begin
            state_reg   <= DONE;
            address_reg <= '0;
            finish_reg  <= 1'b1;
          end else begin
            i_reg       <= i_next;
            k_reg       <= k_next;
            state_reg   <= RD_I;
            address_reg <= i_next;
          end
        end

        DONE: begin
          // Terminal until reset; start is ignored here.
          address_reg <= '0;
          finish_reg  <= 1'b1;
        end

        default: begin
          state_reg   <= IDLE;
          address_reg <= '0;
        end
      endcase
    end
  end

  assign address = address_reg;
  assign data    = data_reg;
  assign wren    = wren_reg;
  assign finish  = finish_reg;

endmodule

// File: tb/tb_ksa.sv
module tb_ksa;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [23:0] secret_key;
  logic [7:0]  address;
  logic [7:0]  data;
  logic [7:0]  q;
  logic        wren;
  logic        finish;

  int checks = 0;
  int errors = 0;

  // Behavioural S memory: 256x8, one-cycle registered read.
  logic [7:0] mem [256];
  logic       init_mem;

  // Observed writes {address, data} and the reference model's expectations.
  logic [15:0] wq [$];
  logic [15:0] exp_wr [$];
  int          exp_wr_iter [$];
  int          exp_s [256];
  int          exp_cycles;

  ksa dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .secret_key (secret_key),
    .address    (address),
    .data       (data),
    .q          (q),
    .wren       (wren),
    .finish     (finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (init_mem) begin
      for (int a = 0; a < 256; a++) mem[a] <= 8'(a);
    end else begin
      if (wren) mem[address] <= data;
      q <= mem[address];
    end
  end

  always @(negedge clk) begin
    if (rst_n && wren) wq.push_back({address, data});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] wq_at(input int n);
    if (n < wq.size()) return wq[n];
    return 16'hxxxx;
  endfunction

  // Plain RC4 key schedule on an integer array; also lists the memory
  // writes a straightforward read-read-write-write swap would issue.
  task automatic model(input logic [23:0] key);
    int s [256];
    int j;
    int kb;
    int tmp;
    j = 0;
    exp_cycles = 0;
    exp_wr.delete();
    exp_wr_iter.delete();
    for (int a = 0; a < 256; a++) s[a] = a;
    for (int i = 0; i < 256; i++) begin
      kb = int'((key >> (8 * (2 - (i % 3)))) & 24'hFF);
      j = (j + s[i] + kb) % 256;
`ifdef KSA_SWAP_SKIP_EN
      if (i == j) begin
        exp_cycles += 5;
      end else begin
        exp_wr.push_back({8'(i), 8'(s[j])});
        exp_wr.push_back({8'(j), 8'(s[i])});
        exp_wr_iter.push_back(i);
        exp_wr_iter.push_back(i);
        exp_cycles += 7;
      end
`else
      exp_wr.push_back({8'(i), 8'(s[j])});
      exp_wr.push_back({8'(j), 8'(s[i])});
      exp_wr_iter.push_back(i);
      exp_wr_iter.push_back(i);
      exp_cycles += 7;
`endif
      tmp = s[i];
      s[i] = s[j];
      s[j] = tmp;
    end
    for (int a = 0; a < 256; a++) exp_s[a] = s[a];
  endtask

  // Reset, re-init S, and present start with the given key (start seen at the
  // next rising edge after return).
  task automatic prepare(input logic [23:0] key);
    @(negedge clk);
    rst_n      = 1'b0;
    start      = 1'b0;
    secret_key = key;
    init_mem   = 1'b1;
    @(negedge clk);
    rst_n    = 1'b1;
    init_mem = 1'b0;
    wq.delete();
    check("idle_finish", 32'(finish), 0);
    check("idle_wren", 32'(wren), 0);
    start = 1'b1;
  endtask

  task automatic run(input logic [23:0] key, input bit hold, input string name);
    int cyc;
    int late_wren;
    model(key);
    prepare(key);
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    cyc = 0;
    while (!finish && cyc < 4000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("finish", 32'(finish), 1);
    check("cycles", 32'(cyc), 32'(exp_cycles));
    check("wr_count", 32'(wq.size()), 32'(exp_wr.size()));
    for (int n = 0; n < exp_wr.size(); n++) check("wr", 32'(wq_at(n)), 32'(exp_wr[n]));
    for (int a = 0; a < 256; a++) check("final_s", 32'(mem[a]), 32'(exp_s[a]));
    if (hold) begin
      late_wren = 0;
      for (int c = 0; c < 50; c++) begin
        @(negedge clk);
        if (wren) late_wren++;
      end
      check("no_restart_wren", 32'(late_wren), 0);
      check("done_finish", 32'(finish), 1);
      check("done_addr", 32'(address), 0);
    end
    start = 1'b0;
    $display("run %s key=%06h cycles=%0d writes=%0d", name, key, cyc, wq.size());
  endtask

  task automatic reset_mid_run(input logic [23:0] key);
    int target;
    int wcount;
    bit hit;
    model(key);
    target = 0;
    while (target < exp_wr_iter.size() && exp_wr_iter[target] < 100) target++;
    prepare(key);
    @(posedge clk);
    #1;
    start  = 1'b0;
    wcount = 0;
    hit    = 1'b0;
    for (int c = 0; c < 4000 && !hit; c++) begin
      @(negedge clk);
      if (wren) begin
        if (wcount == target) hit = 1'b1;
        else wcount++;
      end
    end
    check("mid_run_reached", 32'(hit), 1);
    check("mid_wr_i_addr", 32'(address), 32'(exp_wr[target][15:8]));
    rst_n = 1'b0;
    #1;
    check("rst_wren", 32'(wren), 0);
    check("rst_finish", 32'(finish), 0);
    check("rst_addr", 32'(address), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_idle_wren", 32'(wren), 0);
    check("post_rst_idle_addr", 32'(address), 0);
    $display("run mid_reset key=%06h reset_at_write=%0d", key, target);
    run(key, 1'b0, "after_reset");
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    secret_key = '0;
    init_mem   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_addr", 32'(address), 0);
    check("reset_data", 32'(data), 0);
    check("reset_wren", 32'(wren), 0);
    check("reset_finish", 32'(finish), 0);
    rst_n = 1'b1;

    run(24'h000000, 1'b0, "key0");
`ifdef KSA_SWAP_SKIP_EN
    // Iterations 0 and 1 are self-swaps, so iteration 2 writes first.
    check("skip_first_wr_i", 32'(wq_at(0)), 32'h0203);
    check("skip_first_wr_j", 32'(wq_at(1)), 32'h0302);
`else
    check("iter0_j", 32'(wq_at(1) >> 8), 0);
    check("iter1_j", 32'(wq_at(3) >> 8), 1);
    check("iter2_wr_i", 32'(wq_at(4)), 32'h0203);
    check("iter2_wr_j", 32'(wq_at(5)), 32'h0302);
`endif

    run(24'h000001, 1'b0, "key1");
`ifndef KSA_SWAP_SKIP_EN
    check("key1_iter0_j", 32'(wq_at(1) >> 8), 0);
`endif

    run(24'($urandom()), 1'b1, "hold_start");
    reset_mid_run(24'($urandom()));
    run(24'hFFFFFF, 1'b0, "keyFFFFFF");
    for (int r = 0; r < 3; r++) run(24'($urandom()), 1'b0, "random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
